// File: rtl/nn_window_gen.sv
// nn_window_gen: raster pixel stream in, every full 3x3 window out.
// Two line buffers feed a 3x3 shift register behind one output stage.
module nn_window_gen #(
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  parameter  int PIX_W = 9,
  localparam int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_pix,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] win_flat,
  output logic [CW-1:0]      m_row,
  output logic [CW-1:0]      m_col,
  output logic               m_last
);

  localparam logic [CW-1:0] LP_W1  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LP_H1  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] LP_TWO = CW'(2);

  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_win [9];
  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_valid;
  logic             r_last;
  logic [CW-1:0]    r_mrow;
  logic [CW-1:0]    r_mcol;

  logic             w_acc;
  logic [CW-1:0]    w_r;
  logic [CW-1:0]    w_c;
  logic             w_eol;
  logic             w_eof;
  logic             w_emit;
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;

  assign s_ready = !r_valid | m_ready;
  assign w_acc   = s_valid & s_ready;
  // s_sof forces this beat to be pixel (0,0)
  assign w_r     = s_sof ? '0 : r_row;
  assign w_c     = s_sof ? '0 : r_col;
  assign w_eol   = (w_c == LP_W1);
  assign w_eof   = w_eol & (w_r == LP_H1);
  assign w_emit  = (w_r >= LP_TWO) & (w_c >= LP_TWO);
  assign w_top   = r_lb1[w_c];
  assign w_mid   = r_lb0[w_c];

  assign m_valid = r_valid;
  assign m_row   = r_mrow;
  assign m_col   = r_mcol;
  assign m_last  = r_last;

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 9; i++)
      win_flat[i*PIX_W +: PIX_W] = r_win[i];
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_c] <= w_mid;
      r_lb0[w_c] <= s_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++)
        r_win[i] <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < 3; k++) begin
        r_win[3*k]   <= r_win[3*k+1];
        r_win[3*k+1] <= r_win[3*k+2];
      end
      r_win[2] <= w_top;
      r_win[5] <= w_mid;
      r_win[8] <= s_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_mrow  <= '0;
      r_mcol  <= '0;
    end else if (w_acc) begin
      r_col <= w_eol ? '0 : w_c + 1'b1;
      if (w_eol)
        r_row <= (w_r == LP_H1) ? '0 : w_r + 1'b1;
      else
        r_row <= w_r;
      r_valid <= w_emit;
      if (w_emit) begin
        r_mrow <= w_r - 1'b1;
        r_mcol <= w_c - 1'b1;
        r_last <= w_eof;
      end
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nn_window_gen.sv
// tb_nn_window_gen: 4x4 frames through nn_window_gen.
// Scoreboard of expected windows built from a full-frame image model.
module tb_nn_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 9;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [P-1:0]   s_pix = '0;
  logic           s_sof = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [9*P-1:0] win_flat;
  logic [CW-1:0]  m_row;
  logic [CW-1:0]  m_col;
  logic           m_last;

  int total = 0;
  int bad   = 0;
  int nwin  = 0;

  typedef struct {
    logic [9*P-1:0] w;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic           last;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e_m;
  exp_t         e_c;
  logic [P-1:0] mimg [H][W];
  int           mr = 0;
  int           mc = 0;
  int           pr;
  int           pc;

  always #5 clk = ~clk;

  nn_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pix    (s_pix),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .win_flat (win_flat),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last)
  );

  // image model: store each accepted pixel at its position
  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      pr = s_sof ? 0 : mr;
      pc = s_sof ? 0 : mc;
      mimg[pr][pc] = s_pix;
      if (pr >= 2 && pc >= 2) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            e_m.w[(3*rr+cc)*P +: P] = mimg[pr-2+rr][pc-2+cc];
        e_m.row  = CW'(pr - 1);
        e_m.col  = CW'(pc - 1);
        e_m.last = (pr == H-1) && (pc == W-1);
        sbq.push_back(e_m);
      end
      if (pc == W-1) begin
        mc = 0;
        mr = (pr == H-1) ? 0 : pr + 1;
      end else begin
        mc = pc + 1;
        mr = pr;
      end
    end
  end

  always @(negedge rst_n) begin
    sbq.delete();
    mr = 0;
    mc = 0;
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got w=%h r=%0d c=%0d exp=none", win_flat, m_row, m_col);
      end else begin
        e_c = sbq.pop_front();
        nwin++;
        if ({win_flat, m_row, m_col, m_last} !== {e_c.w, e_c.row, e_c.col, e_c.last}) begin
          bad++;
          $display("FAIL sb_window got w=%h r=%0d c=%0d l=%0b exp w=%h r=%0d c=%0d l=%0b",
                   win_flat, m_row, m_col, m_last, e_c.w, e_c.row, e_c.col, e_c.last);
        end
      end
    end
  end

  function automatic logic [9*P-1:0] mk9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    logic [9*P-1:0] v;
    v = {P'(a8), P'(a7), P'(a6), P'(a5), P'(a4), P'(a3), P'(a2), P'(a1), P'(a0)};
    return v;
  endfunction

  task automatic send(input int v, input bit sof);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_pix   = P'(v);
    s_sof   = sof;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stalled exp=accepted");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
    total++;
    if (win_flat !== '0) begin bad++; $display("FAIL rst_win got=%h exp=0", win_flat); end
    total++;
    if ({m_row, m_col, m_last} !== 5'b0) begin
      bad++; $display("FAIL rst_meta got=%0d/%0d/%b exp=0/0/0", m_row, m_col, m_last);
    end
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame(input bit first_sof, input string tag);
    int w0;
    w0 = nwin;
    m_ready = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(4*r + c, first_sof && r == 0 && c == 0);
        if (r == 2 && c == 2) begin
          total++;
          if (m_valid !== 1'b1 || win_flat !== mk9(0,1,2,4,5,6,8,9,10) ||
              m_row !== 2'd1 || m_col !== 2'd1 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL %s_first got v=%b w=%h r=%0d c=%0d l=%b exp v=1 w=%h r=1 c=1 l=0",
                     tag, m_valid, win_flat, m_row, m_col, m_last, mk9(0,1,2,4,5,6,8,9,10));
          end
        end
        if (r == 3 && c == 3) begin
          total++;
          if (m_valid !== 1'b1 || win_flat !== mk9(5,6,7,9,10,11,13,14,15) ||
              m_row !== 2'd2 || m_col !== 2'd2 || m_last !== 1'b1) begin
            bad++;
            $display("FAIL %s_last got v=%b w=%h r=%0d c=%0d l=%b exp v=1 w=%h r=2 c=2 l=1",
                     tag, m_valid, win_flat, m_row, m_col, m_last, mk9(5,6,7,9,10,11,13,14,15));
          end
        end
      end
    wait_drain();
    total++;
    if (nwin - w0 != 4 || sbq.size() != 0) begin
      bad++; $display("FAIL %s_count got=%0d exp=4 left=%0d", tag, nwin - w0, sbq.size());
    end
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = nwin;
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < W*H; i++)
          send(20 + i, i == 0);
      end
      begin
        int n;
        logic [9*P-1:0] hold;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 100) begin @(negedge clk); n++; end
        hold = win_flat;
        repeat (5) begin
          total++;
          if (s_ready !== 1'b0 || m_valid !== 1'b1 || win_flat !== hold) begin
            bad++;
            $display("FAIL bp_hold got rdy=%b v=%b w=%h exp rdy=0 v=1 w=%h",
                     s_ready, m_valid, win_flat, hold);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();
    total++;
    if (nwin - w0 != 4 || sbq.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d exp=4 left=%0d", nwin - w0, sbq.size());
    end
  endtask

  task automatic test_sign();
    logic [P-1:0] sp [2];
    sp[0] = 9'h100;
    sp[1] = 9'h0FF;
    m_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        send((i == 10) ? int'(sp[f]) : i, i == 0);
        if (i == 10) begin
          total++;
          if (m_valid !== 1'b1 || win_flat[8*P +: P] !== sp[f]) begin
            bad++;
            $display("FAIL sign_slot8 got v=%b pix=%h exp v=1 pix=%h", m_valid, win_flat[8*P +: P], sp[f]);
          end
        end
      end
      wait_drain();
    end
  endtask

  task automatic test_sof_mid();
    int w0;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      send(4*(i/4) + (i%4), i == 0);
    w0 = nwin;
    for (int i = 0; i < W*H; i++) begin
      send(100 + i, i == 0);
      if (i < 10) begin
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL sof_early idx=%0d got v=%b exp v=0", i, m_valid); end
      end
      if (i == 10) begin
        total++;
        if (m_valid !== 1'b1 || win_flat !== mk9(100,101,102,104,105,106,108,109,110)) begin
          bad++;
          $display("FAIL sof_first got v=%b w=%h exp v=1 w=%h", m_valid, win_flat,
                   mk9(100,101,102,104,105,106,108,109,110));
        end
      end
    end
    wait_drain();
    total++;
    if (nwin - w0 != 4 || sbq.size() != 0) begin
      bad++; $display("FAIL sof_count got=%0d exp=4 left=%0d", nwin - w0, sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    time t0;
    time t1;
    w0 = nwin;
    m_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 2*W*H; i++)
      send(40*(i/16) + (i%16), 1'b0);
    t1 = $time;
    total++;
    if ((t1 - t0) / 10 != 32) begin
      bad++; $display("FAIL b2b_cycles got=%0d exp=32", (t1 - t0) / 10);
    end
    wait_drain();
    total++;
    if (nwin - w0 != 8 || sbq.size() != 0) begin
      bad++; $display("FAIL b2b_count got=%0d exp=8 left=%0d", nwin - w0, sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++)
      send(60 + i, i == 0);
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got v=%b exp v=1", m_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || win_flat !== '0) begin
      bad++; $display("FAIL rmid_clear got v=%b w=%h exp v=0 w=0", m_valid, win_flat);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_frame(1'b0, "rmid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame(1'b1, "frame");
    test_backpressure();
    test_sign();
    test_sof_mid();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
